// File: rtl/bru_pkg.sv
// bru_pkg: shared funct3 encoding and sizing helpers for the branch resolve unit
package bru_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } funct3_e;

    // Index width for a table of n entries; never below one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Weakly-not-taken start value for a counter of the given width.
    function automatic int cnt_init(input int cnt_bits);
        return (1 << (cnt_bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/bht_sat_counter_array.sv
// bht_sat_counter_array: saturating counter table with combinational read and one update port
module bht_sat_counter_array
    import bru_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int CNT_BITS = 2,
    parameter int IDX_W    = idx_w(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_msb,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_inc
);

    localparam logic [CNT_BITS-1:0] INIT = CNT_BITS'(cnt_init(CNT_BITS));
    localparam logic [CNT_BITS-1:0] MAX  = '1;

    logic [CNT_BITS-1:0] cnt [ENTRIES];
    logic [CNT_BITS-1:0] cur;
    logic [CNT_BITS-1:0] nxt;

    assign rd_msb = cnt[rd_idx][CNT_BITS-1];
    assign cur    = cnt[upd_idx];

    // Saturating step toward taken or not-taken.
    always_comb begin
        nxt = upd_inc ? ((cur == MAX) ? MAX : cur + 1'b1)
                      : ((cur == '0) ? '0 : cur - 1'b1);
    end

    // Counter storage; reset returns every entry to weakly-not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) cnt[i] <= INIT;
        end else if (upd_en) begin
            cnt[upd_idx] <= nxt;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: branch condition evaluation, bimodal prediction and registered resolution (optional perf counters via BRU_PERF_CNT_EN)
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_BITS    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] lk_pc,
    output logic            lk_pred_taken,
    input  logic            res_valid,
    input  logic [2:0]      res_funct3,
    input  logic            res_z,
    input  logic            res_n,
    input  logic            res_v,
    input  logic            res_carry,
    input  logic [XLEN-1:0] res_pc,
    input  logic [XLEN-1:0] res_target,
    input  logic            res_pred_taken,
    output logic            out_valid,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic [XLEN-1:0] out_redirect_pc,
`ifdef BRU_PERF_CNT_EN
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_taken,
    output logic [31:0]     perf_mispredicts,
`endif
    output logic            out_illegal
);

    localparam int IDX_W = idx_w(BHT_ENTRIES);

    logic taken;
    logic illegal;

    assign illegal = (res_funct3[2:1] == 2'b01);

    // Branch condition from the subtract flags; illegal encodings never take.
    always_comb begin
        taken = 1'b0;
        case (funct3_e'(res_funct3))
            BEQ:     taken = res_z;
            BNE:     taken = ~res_z;
            BLT:     taken = res_n ^ res_v;
            BGE:     taken = ~(res_n ^ res_v);
            BLTU:    taken = ~res_carry;
            BGEU:    taken = res_carry;
            default: taken = 1'b0;
        endcase
    end

    bht_sat_counter_array #(
        .ENTRIES  (BHT_ENTRIES),
        .CNT_BITS (CNT_BITS),
        .IDX_W    (IDX_W)
    ) u_bht (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (lk_pc[IDX_W+1:2]),
        .rd_msb  (lk_pred_taken),
        .upd_en  (res_valid & ~illegal),
        .upd_idx (res_pc[IDX_W+1:2]),
        .upd_inc (taken)
    );

    // Resolution register feeding the flush logic; qualifiers gated by res_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_taken       <= 1'b0;
            out_mispredict  <= 1'b0;
            out_illegal     <= 1'b0;
            out_redirect_pc <= '0;
        end else begin
            out_valid       <= res_valid;
            out_taken       <= taken;
            out_mispredict  <= res_valid & ~illegal & (taken != res_pred_taken);
            out_illegal     <= res_valid & illegal;
            out_redirect_pc <= taken ? res_target : res_pc + XLEN'(4);
        end
    end

`ifdef BRU_PERF_CNT_EN
    // Event counters over registered results, illegal resolves excluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches    <= '0;
            perf_taken       <= '0;
            perf_mispredicts <= '0;
        end else begin
            perf_branches    <= perf_branches + 32'(out_valid & ~out_illegal);
            perf_taken       <= perf_taken + 32'(out_valid & out_taken & ~out_illegal);
            perf_mispredicts <= perf_mispredicts + 32'(out_mispredict);
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table, directed and random checks against a behavioural model
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] lk_pc = '0;
    logic        lk_pred_taken;
    logic        res_valid = 1'b0;
    logic [2:0]  res_funct3 = '0;
    logic        res_z = 1'b0, res_n = 1'b0, res_v = 1'b0, res_carry = 1'b0;
    logic [31:0] res_pc = '0, res_target = '0;
    logic        res_pred_taken = 1'b0;
    logic        out_valid, out_taken, out_mispredict, out_illegal;
    logic [31:0] out_redirect_pc;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branches, perf_taken, perf_mispredicts;
`endif

    int n_pass = 0;
    int n_total = 0;
    int bht [64];

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lk_pc           (lk_pc),
        .lk_pred_taken   (lk_pred_taken),
        .res_valid       (res_valid),
        .res_funct3      (res_funct3),
        .res_z           (res_z),
        .res_n           (res_n),
        .res_v           (res_v),
        .res_carry       (res_carry),
        .res_pc          (res_pc),
        .res_target      (res_target),
        .res_pred_taken  (res_pred_taken),
        .out_valid       (out_valid),
        .out_taken       (out_taken),
        .out_mispredict  (out_mispredict),
        .out_redirect_pc (out_redirect_pc),
`ifdef BRU_PERF_CNT_EN
        .perf_branches   (perf_branches),
        .perf_taken      (perf_taken),
        .perf_mispredicts(perf_mispredicts),
`endif
        .out_illegal     (out_illegal)
    );

    typedef struct {
        logic [2:0]  f3;
        logic        z, n, v, c;
        logic [31:0] pc;
        logic        pred;
        logic        exp_taken;
        logic        exp_ill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic logic m_pred(input logic [31:0] pc);
        return bht[idx(pc)] >= 2;
    endfunction

    function automatic logic m_taken(input logic [2:0] f3, input logic z, n, v, c);
        case (f3)
            3'b000: return z;
            3'b001: return !z;
            3'b100: return n != v;
            3'b101: return n == v;
            3'b110: return !c;
            3'b111: return c;
            default: return 1'b0;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) bht[i] = 1;
    endtask

    // One resolve cycle: check the pre-edge lookup, clock, check registered result, update model.
    task automatic resolve(input logic vld, input logic [2:0] f3, input logic z, n, v, c,
                           input logic [31:0] pc, tgt, input logic pred, input logic [31:0] lpc,
                           input string tag);
        logic t, ill;
        res_valid = vld; res_funct3 = f3; res_z = z; res_n = n; res_v = v; res_carry = c;
        res_pc = pc; res_target = tgt; res_pred_taken = pred; lk_pc = lpc;
        #1;
        chk({tag, ".lookup"}, 32'(lk_pred_taken), 32'(m_pred(lpc)));
        t = m_taken(f3, z, n, v, c);
        ill = (f3 == 3'b010) || (f3 == 3'b011);
        @(posedge clk); #1;
        chk({tag, ".valid"}, 32'(out_valid), 32'(vld));
        chk({tag, ".illegal"}, 32'(out_illegal), 32'(vld && ill));
        chk({tag, ".mispredict"}, 32'(out_mispredict), 32'(vld && !ill && (t != pred)));
        if (vld) begin
            chk({tag, ".taken"}, 32'(out_taken), 32'(t));
            chk({tag, ".redirect"}, out_redirect_pc, t ? tgt : pc + 32'd4);
        end
        if (vld && !ill) bht[idx(pc)] = t ? ((bht[idx(pc)] == 3) ? 3 : bht[idx(pc)] + 1)
                                          : ((bht[idx(pc)] == 0) ? 0 : bht[idx(pc)] - 1);
        res_valid = 1'b0;
    endtask

    task automatic idle();
        res_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{3'b000, 1, 0, 0, 0, 32'h1000, 0, 1, 0};
        vecs[1]  = '{3'b001, 1, 0, 0, 0, 32'h1004, 0, 0, 0};
        vecs[2]  = '{3'b100, 0, 1, 0, 0, 32'h1008, 0, 1, 0};
        vecs[3]  = '{3'b100, 0, 1, 1, 0, 32'h100c, 1, 0, 0};
        vecs[4]  = '{3'b101, 0, 0, 1, 0, 32'h1010, 0, 0, 0};
        vecs[5]  = '{3'b101, 0, 1, 1, 0, 32'h1014, 0, 1, 0};
        vecs[6]  = '{3'b110, 0, 0, 0, 0, 32'h1018, 0, 1, 0};
        vecs[7]  = '{3'b111, 0, 0, 0, 0, 32'h101c, 1, 0, 0};
        vecs[8]  = '{3'b111, 0, 0, 0, 1, 32'h1020, 1, 1, 0};
        vecs[9]  = '{3'b011, 1, 1, 0, 1, 32'h1024, 1, 0, 1};
        vecs[10] = '{3'b010, 1, 1, 0, 1, 32'h1028, 0, 0, 1};

        m_reset();
        #12;
        lk_pc = 32'h100;
        #1;
        chk("reset.lookup", 32'(lk_pred_taken), 32'd0);
        chk("reset.valid", 32'(out_valid), 32'd0);
        chk("reset.taken", 32'(out_taken), 32'd0);
        chk("reset.mispredict", 32'(out_mispredict), 32'd0);
        chk("reset.illegal", 32'(out_illegal), 32'd0);
        chk("reset.redirect", out_redirect_pc, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // BEQ twice with a stale not-taken prediction
        resolve(1, 3'b000, 1, 0, 0, 0, 32'h100, 32'h800, 0, 32'h100, "beq1");
        chk("beq1.mispredict_const", 32'(out_mispredict), 32'd1);
        chk("beq1.redirect_const", out_redirect_pc, 32'h800);
        #1 chk("beq1.pred_after", 32'(lk_pred_taken), 32'd1);
        resolve(1, 3'b000, 1, 0, 0, 0, 32'h100, 32'h800, 0, 32'h100, "beq2");
        chk("beq2.mispredict_const", 32'(out_mispredict), 32'd1);

        // Saturation at 0x40
        for (int i = 0; i < 5; i++) resolve(1, 3'b111, 0, 0, 0, 1, 32'h40, 32'h80, 1, 32'h40, "sat");
        resolve(1, 3'b111, 0, 0, 0, 0, 32'h40, 32'h80, 1, 32'h40, "unsat");
        lk_pc = 32'h40; #1;
        chk("unsat.pred_still_taken", 32'(lk_pred_taken), 32'd1);

        // PC+4 wrap
        resolve(1, 3'b100, 0, 1, 1, 0, 32'hFFFFFFFC, 32'h1234, 0, 32'h0, "wrap");
        chk("wrap.redirect_const", out_redirect_pc, 32'h0);

        // Alias: index 0 is at 3; drive it down while looking up 0x200
        resolve(1, 3'b000, 0, 0, 0, 0, 32'h100, 32'h800, 1, 32'h200, "alias1");
        resolve(1, 3'b000, 0, 0, 0, 0, 32'h100, 32'h800, 1, 32'h200, "alias2");
        chk("alias.old_before_edge_was_1", 32'(m_pred(32'h200)), 32'(lk_pred_taken));
        chk("alias.new_after_edge", 32'(lk_pred_taken), 32'd0);

        // Illegal funct3 leaves the table alone
        resolve(1, 3'b010, 1, 0, 0, 0, 32'h40, 32'h80, 1, 32'h40, "illegal");
        chk("illegal.flag_const", 32'(out_illegal), 32'd1);
        chk("illegal.bht_kept", 32'(lk_pred_taken), 32'd1);

        // Table-driven condition vectors
        for (int i = 0; i < 11; i++) begin
            resolve(1, vecs[i].f3, vecs[i].z, vecs[i].n, vecs[i].v, vecs[i].c, vecs[i].pc,
                    32'hA000 + 32'(i), vecs[i].pred, vecs[i].pc, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_taken", i), 32'(out_taken), 32'(vecs[i].exp_taken));
            chk($sformatf("vec%0d.tbl_illegal", i), 32'(out_illegal), 32'(vecs[i].exp_ill));
        end

        // Idle cycle clears qualifiers
        idle();
        chk("idle.valid", 32'(out_valid), 32'd0);
        chk("idle.mispredict", 32'(out_mispredict), 32'd0);

        // Randomized stream with back-to-back resolves
        for (int i = 0; i < 400; i++) begin
            logic [2:0] f3;
            f3 = 3'($urandom_range(0, 7));
            resolve($urandom_range(0, 9) != 0, f3, 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), {$urandom_range(0, 255), 2'($urandom)} << 0, $urandom,
                    1'($urandom), 32'($urandom_range(0, 1023)), "rnd");
        end

        // Asynchronous reset mid-stream with a resolve in flight
        resolve(1, 3'b000, 1, 0, 0, 0, 32'h100, 32'h900, 0, 32'h100, "pre_rst");
        res_valid = 1'b1; res_funct3 = 3'b000; res_z = 1'b1; res_pred_taken = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.valid", 32'(out_valid), 32'd0);
        chk("async_rst.taken", 32'(out_taken), 32'd0);
        chk("async_rst.mispredict", 32'(out_mispredict), 32'd0);
        chk("async_rst.redirect", out_redirect_pc, 32'd0);
        lk_pc = 32'h100; #1;
        chk("async_rst.bht", 32'(lk_pred_taken), 32'd0);
        m_reset();
        res_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst.valid", 32'(out_valid), 32'd0);
        resolve(1, 3'b001, 0, 0, 0, 0, 32'h100, 32'h300, 0, 32'h100, "post_rst");
        #1 chk("post_rst.pred", 32'(lk_pred_taken), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
